// File: rtl/stream_selector_n_w.sv
// stream_selector_n_w
// N-channel, W-bit registered stream selector with valid/ready handshakes.
// Fixed-select mode picks the channel named by `sel`; the optional
// round-robin mode (compiled in when the macro SEL_RR_EN is defined) scans
// for the next valid channel after the last one granted.
// Without SEL_RR_EN the `mode` input is ignored and only fixed select exists;
// the port list is the same in both builds.
// in_ready is combinational (out_ready / in_valid / sel / mode -> in_ready);
// every out_* signal comes straight from a register.

module stream_selector_n_w #(
    parameter int N  = 8,
    parameter int W  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [IW-1:0]        sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N-1:0][W-1:0]  in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [W-1:0]         out_data,
    output logic [IW-1:0]        out_ch,
    input  logic                 out_ready
);

    // Channel index loaded into the round-robin pointer at reset, so that the
    // first scan starts at channel 0.
    localparam logic [IW-1:0] LAST_CH = IW'(N - 1);

    // ------------------------------------------------------------------
    // Output register state
    // ------------------------------------------------------------------
    logic          out_valid_r;
    logic [W-1:0]  out_data_r;
    logic [IW-1:0] out_ch_r;

    // ------------------------------------------------------------------
    // Grant and handshake signals
    // ------------------------------------------------------------------
    logic          accept_s;     // output register can take a new word
    logic          rr_mode_s;    // effective round-robin mode
    logic [31:0]   sel_ext_s;    // sel zero-extended for the range check
    logic          fix_vld_s;    // fixed-mode grant exists
    logic          rr_vld_s;     // round-robin grant exists
    logic [IW-1:0] rr_idx_s;     // round-robin granted channel
    logic          grant_vld_s;  // final grant exists
    logic [IW-1:0] grant_idx_s;  // final granted channel
    logic          xfer_s;       // handshake completes this cycle
    logic [N-1:0]  in_ready_s;

    // A full register may take a new word in the same cycle it is drained.
    assign accept_s = !out_valid_r || out_ready;

`ifdef SEL_RR_EN
    logic [IW-1:0] ptr_r;        // last channel granted in round-robin mode

    assign rr_mode_s = mode;

    // Round-robin scan: first valid channel at (ptr+1) mod N, ascending with
    // wrap. The loop walks from the farthest candidate to the nearest so the
    // nearest valid channel is the one left in rr_idx_s.
    always_comb begin
        logic [IW-1:0] cand;
        logic          hit;
        cand     = '0;
        hit      = 1'b0;
        rr_vld_s = 1'b0;
        rr_idx_s = '0;
        for (int i = N; i >= 1; i--) begin
            cand     = IW'((int'(ptr_r) + i) % N);
            hit      = in_valid[cand];
            rr_idx_s = hit ? cand : rr_idx_s;
            rr_vld_s = rr_vld_s | hit;
        end
    end

    // Round-robin pointer: follows the granted channel, only in round-robin
    // mode; fixed-mode transfers and mode switches leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= LAST_CH;
        end else if (xfer_s && rr_mode_s) begin
            ptr_r <= grant_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    logic unused_mode_s;

    // Without round-robin support the block is always in fixed mode.
    assign rr_mode_s     = 1'b0;
    assign unused_mode_s = mode;
    assign rr_vld_s      = 1'b0;
    assign rr_idx_s      = '0;
`endif

    // Fixed-select grant: sel must name an existing channel whose valid is set.
    always_comb begin
        sel_ext_s = {{(32 - IW){1'b0}}, sel};
        fix_vld_s = 1'b0;
        if (sel_ext_s < 32'(N)) begin
            fix_vld_s = in_valid[sel];
        end else begin
            fix_vld_s = 1'b0;
        end
    end

    // Choose the grant for the active mode.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        if (rr_mode_s) begin
            grant_vld_s = rr_vld_s;
            grant_idx_s = rr_idx_s;
        end else begin
            grant_vld_s = fix_vld_s;
            grant_idx_s = sel;
        end
    end

    // A granted channel's valid is already known to be set, so a transfer is a
    // grant that the output register can accept. Nothing completes in reset.
    assign xfer_s = rst_n && grant_vld_s && accept_s;

    // Per-channel ready: only the granted channel can see ready, and only
    // when the output register can accept and reset is not asserted.
    always_comb begin
        in_ready_s = '0;
        if (rst_n && grant_vld_s) begin
            in_ready_s[grant_idx_s] = accept_s;
        end else begin
            in_ready_s = '0;
        end
    end

    assign in_ready = in_ready_s;

    // Output register: load on a transfer, go empty when drained with nothing
    // granted (data/channel keep their last values), otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_data[grant_idx_s];
            out_ch_r    <= grant_idx_s;
        end else if (accept_s) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_ch_r    <= out_ch_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_ch_r    <= out_ch_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;

endmodule
